ls_access_ctrl: RTL and testbench

Sequencing and arbitration controller for the SPU's 128-bit local-store data memory. It sits between two requesters and a single-port synchronous quadword memory:
- the odd-pipe load/store unit (unit ID 7), which can read and write;
- the instruction-fetch unit, which only reads.

After reset it zero-fills the memory, then grants one access per cycle. The load/store unit has priority, with a starvation guard for fetch.

---
 rtl/spu_pkg.sv | 18 +
 rtl/ls_fetch_arbiter.sv | 43 ++++
 rtl/ls_access_ctrl.sv | 120 ++++++++++++
 tb/tb_ls_access_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/spu_pkg.sv
// Shared SPU definitions: unit IDs, quadword geometry, local-store controller
// state encoding and the byte-address to quadword-index mapping.
package spu_pkg;

    localparam logic [2:0] UNIT_LS  = 3'd7;
    localparam int         QW_BYTES = 16;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ls_state_e;

    // Full-width quadword number; callers keep only the bits their store decodes.
    function automatic logic [31:0] qw_index(input logic [31:0] addr);
        return addr >> $clog2(QW_BYTES);
    endfunction

endpackage

// File: rtl/ls_fetch_arbiter.sv
// Load/store vs. fetch grant logic: load/store wins, except that fetch is
// forced through after STARVE_MAX consecutive refused cycles.
module ls_fetch_arbiter #(
    parameter int STARVE_MAX = 3,
    parameter int CNT_W      = $clog2(STARVE_MAX + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic ls_req,
    input  logic if_req,
    output logic ls_ready,
    output logic if_ready
);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             force_if;

    always_comb begin
        force_if = if_req && (starve_cnt_q == CNT_W'(STARVE_MAX));
        if_ready = run && (force_if || !ls_req);
        ls_ready = run && ls_req && !force_if;
    end

    // Counts only refused fetch cycles while running; any fetch grant restarts it.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!run || !if_req || if_ready) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != CNT_W'(STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/ls_access_ctrl.sv
// Local-store access controller: zero-fills the quadword memory after reset,
// then grants one load/store or fetch access per cycle with 1-cycle read return.
module ls_access_ctrl
    import spu_pkg::*;
#(
    parameter int DEPTH      = 2048,
    parameter int IDX_W      = $clog2(DEPTH),
    parameter int STARVE_MAX = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ls_req,
    input  logic             ls_we,
    input  logic [31:0]      ls_addr,
    input  logic [127:0]     ls_wdata,
    output logic             ls_ready,
    output logic             ls_rvalid,
    input  logic             if_req,
    input  logic [31:0]      if_addr,
    output logic             if_ready,
    output logic             if_rvalid,
    output logic [127:0]     rdata,
    output logic             init_done,
    output logic             mem_en,
    output logic             mem_we,
    output logic [IDX_W-1:0] mem_idx,
    output logic [127:0]     mem_wdata,
    input  logic [127:0]     mem_rdata
);

    ls_state_e        state_q, state_d;
    logic [IDX_W-1:0] fill_q, fill_d;
    logic             ls_rvalid_q, ls_rvalid_d;
    logic             if_rvalid_q, if_rvalid_d;
    logic             run, ls_acc, if_acc;
    logic [31:0]      ls_qw, if_qw;
    logic             unused_qw_hi;

    assign run          = (state_q == RUN);
    assign ls_qw        = qw_index(ls_addr);
    assign if_qw        = qw_index(if_addr);
    // Addresses past the local store wrap, so the upper quadword bits are dropped.
    assign unused_qw_hi = ^{ls_qw[31:IDX_W], if_qw[31:IDX_W]};

    ls_fetch_arbiter #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .ls_req   (ls_req),
        .if_req   (if_req),
        .ls_ready (ls_ready),
        .if_ready (if_ready)
    );

    assign ls_acc = ls_req && ls_ready;
    assign if_acc = if_req && if_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT;
            fill_q      <= '0;
            ls_rvalid_q <= 1'b0;
            if_rvalid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            ls_rvalid_q <= ls_rvalid_d;
            if_rvalid_q <= if_rvalid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        if (state_q == INIT) begin
            fill_d = fill_q + IDX_W'(1);
            if (fill_q == IDX_W'(DEPTH - 1)) begin
                state_d = RUN;
            end
        end
    end

    always_comb begin
        ls_rvalid_d = ls_acc && !ls_we;
        if_rvalid_d = if_acc;
    end

    // Memory strobes are gated by rst_n so nothing reaches the array mid-reset.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_idx   = '0;
        mem_wdata = '0;
        if (rst_n) begin
            if (state_q == INIT) begin
                mem_en  = 1'b1;
                mem_we  = 1'b1;
                mem_idx = fill_q;
            end else if (ls_acc) begin
                mem_en  = 1'b1;
                mem_we  = ls_we;
                mem_idx = ls_qw[IDX_W-1:0];
                if (ls_we) begin
                    mem_wdata = ls_wdata;
                end
            end else if (if_acc) begin
                mem_en  = 1'b1;
                mem_idx = if_qw[IDX_W-1:0];
            end
        end
    end

    assign init_done = run;
    assign ls_rvalid = ls_rvalid_q;
    assign if_rvalid = if_rvalid_q;
    assign rdata     = mem_rdata;

endmodule

// File: tb/tb_ls_access_ctrl.sv
// Bench for ls_access_ctrl: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_ls_access_ctrl;

    localparam int DEPTH      = 16;
    localparam int IDX_W      = $clog2(DEPTH);
    localparam int STARVE_MAX = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ls_req, ls_we, if_req;
    logic [31:0]      ls_addr, if_addr;
    logic [127:0]     ls_wdata;
    logic             ls_ready, ls_rvalid, if_ready, if_rvalid, init_done;
    logic             mem_en, mem_we;
    logic [IDX_W-1:0] mem_idx;
    logic [127:0]     mem_wdata, mem_rdata, rdata;

    ls_access_ctrl #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_ready(ls_ready), .ls_rvalid(ls_rvalid),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rvalid(if_rvalid),
        .rdata(rdata), .init_done(init_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_idx(mem_idx),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port synchronous memory seen by the DUT.
    logic [127:0] mem [DEPTH];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_idx] <= mem_wdata;
            else        mem_rdata    <= mem[mem_idx];
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: fill progress, starvation count, expected memory contents,
    // and the read (if any) expected to return next cycle.
    int           m_fill;
    bit           m_run;
    int           m_starve;
    bit           m_pl, m_pi;
    logic [127:0] m_data;
    logic [127:0] shadow [DEPTH];

    task automatic model_cycle();
        bit g_if, g_ls, exp_en, exp_we;
        int li, ii, exp_idx;
        logic [127:0] exp_wd;
        if (!rst_n) begin
            chk("rst_ls_ready", ls_ready, 0);
            chk("rst_if_ready", if_ready, 0);
            chk("rst_ls_rvalid", ls_rvalid, 0);
            chk("rst_if_rvalid", if_rvalid, 0);
            chk("rst_init_done", init_done, 0);
            chk("rst_mem_en", mem_en, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_mem_idx", mem_idx, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            m_fill = 0; m_run = 0; m_starve = 0; m_pl = 0; m_pi = 0;
            return;
        end
        li   = int'((ls_addr >> 4) % DEPTH);
        ii   = int'((if_addr >> 4) % DEPTH);
        g_if = m_run && if_req && (m_starve == STARVE_MAX || !ls_req);
        g_ls = m_run && ls_req && !g_if;
        if (ls_req) chk("ls_ready", ls_ready, g_ls);
        if (if_req) chk("if_ready", if_ready, g_if);
        exp_en = !m_run || g_ls || g_if;
        chk("mem_en", mem_en, exp_en);
        if (exp_en) begin
            exp_we  = !m_run || (g_ls && ls_we);
            exp_idx = !m_run ? m_fill : (g_ls ? li : ii);
            exp_wd  = (m_run && g_ls && ls_we) ? ls_wdata : '0;
            chk("mem_we", mem_we, exp_we);
            chk("mem_idx", mem_idx, exp_idx);
            chk("mem_wdata", mem_wdata, exp_wd);
        end
        chk("init_done", init_done, m_run);
        chk("ls_rvalid", ls_rvalid, m_pl);
        chk("if_rvalid", if_rvalid, m_pi);
        if (m_pl || m_pi) chk("rdata", rdata, m_data);
        // advance one clock
        m_pl = g_ls && !ls_we;
        m_pi = g_if;
        if (m_pl) m_data = shadow[li];
        if (m_pi) m_data = shadow[ii];
        if (g_ls && ls_we) shadow[li] = ls_wdata;
        if (!m_run || !if_req || g_if) m_starve = 0;
        else if (m_starve < STARVE_MAX) m_starve++;
        if (!m_run) begin
            shadow[m_fill] = '0;
            m_fill++;
            if (m_fill == DEPTH) m_run = 1;
        end
    endtask

    task automatic cycle_end();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic lr, input logic lw, input logic [31:0] la,
                         input logic [127:0] lwd, input logic ir, input logic [31:0] ia);
        ls_req = lr; ls_we = lw; ls_addr = la; ls_wdata = lwd; if_req = ir; if_addr = ia;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = {4{32'hDEAD_BEEF}} ^ 128'(i);
        mem_rdata = '0;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        cycle_end();
        cycle_end();
        rst_n = 1'b1;

        // zero-fill walks every index, then init_done rises in cycle DEPTH
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            chk("init_we", mem_we, 1);
            chk("init_idx", mem_idx, i);
            chk("init_wdata", mem_wdata, 0);
            chk("init_done_low", init_done, 0);
            cycle_end();
        end
        drive(1, 0, 32'h40, 0, 0, 0);
        #1;
        chk("init_done_16", init_done, 1);
        chk("first_load_ready", ls_ready, 1);
        chk("first_load_idx", mem_idx, 4);
        cycle_end();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("first_load_rvalid", ls_rvalid, 1);
        chk("first_load_zero", rdata, 0);
        cycle_end();

        // store then load of the same quadword, next cycle
        drive(1, 1, 32'h20, 128'd120, 0, 0);
        #1; chk("st_idx", mem_idx, 2); chk("st_we", mem_we, 1);
        cycle_end();
        drive(1, 0, 32'h2F, 0, 0, 0);
        #1; chk("ld_idx", mem_idx, 2); chk("ld_we", mem_we, 0);
        cycle_end();
        drive(0, 0, 0, 0, 0, 0);
        #1; chk("ld_rvalid", ls_rvalid, 1); chk("ld_data", rdata, 120);
        cycle_end();

        // address wrap
        drive(1, 1, 32'h100, 128'd5, 0, 0);
        #1; chk("wrap_st_idx", mem_idx, 0);
        cycle_end();
        drive(1, 0, 32'h0, 0, 0, 0);
        #1; chk("wrap_ld_idx", mem_idx, 0);
        cycle_end();
        drive(0, 0, 0, 0, 0, 0);
        #1; chk("wrap_data", rdata, 5);
        cycle_end();

        // both requesting: LS, LS, LS, fetch, repeating
        for (int k = 0; k < 8; k++) begin
            drive(1, 0, 32'(k * 16), 0, 1, 32'h30);
            #1;
            chk("starve_if_ready", if_ready, (k % 4) == 3);
            chk("starve_ls_ready", ls_ready, (k % 4) != 3);
            chk("starve_if_rvalid", if_rvalid, k > 0 && ((k - 1) % 4) == 3);
            chk("starve_ls_rvalid", ls_rvalid, k > 0 && ((k - 1) % 4) != 3);
            cycle_end();
        end
        drive(0, 0, 0, 0, 0, 0);
        #1; chk("starve_tail_if_rvalid", if_rvalid, 1);
        cycle_end();

        // reset right after a load acceptance suppresses its return
        drive(1, 0, 32'h50, 0, 0, 0);
        cycle_end();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #1; chk("rst_kill_rvalid", ls_rvalid, 0);
        cycle_end();
        rst_n = 1'b1;
        drive(1, 0, 32'h50, 0, 0, 0);
        #1;
        chk("reinit_ready", ls_ready, 0);
        chk("reinit_idx", mem_idx, 0);
        chk("reinit_we", mem_we, 1);
        cycle_end();
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 1; i < DEPTH; i++) cycle_end();

        // fetch alone streams back-to-back
        for (int k = 0; k < 6; k++) begin
            drive(0, 0, 0, 0, 1, 32'h30);
            #1;
            chk("ifonly_ready", if_ready, 1);
            chk("ifonly_rvalid", if_rvalid, k >= 1);
            chk("ifonly_ls_rvalid", ls_rvalid, 0);
            cycle_end();
        end

        // random traffic against the model
        for (int k = 0; k < 600; k++) begin
            drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom,
                  {$urandom, $urandom, $urandom, $urandom},
                  ($urandom_range(0, 2) != 0), $urandom);
            cycle_end();
        end
        drive(0, 0, 0, 0, 0, 0);
        cycle_end();
        cycle_end();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
